// File: rtl/jk_count_ctrl_if.sv
// Command, status and bank-excitation bundle for jk_count_ctrl.
// master drives commands and q feedback; slave is the controller.
interface jk_count_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
);
    logic             start;
    logic             dir;
    logic             clear_first;
    logic [CW-1:0]    steps;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic [CW-1:0]    steps_left;

    modport master (
        output start, dir, clear_first, steps, en, abort, q_fb,
        input  j, k, busy, done, steps_left
    );

    modport slave (
        input  start, dir, clear_first, steps, en, abort, q_fb,
        output j, k, busy, done, steps_left
    );
endinterface

// File: rtl/jk_count_ctrl.sv
// Excitation controller stepping an external jk_ff bank mod-MOD.
// Accepts up/down step commands; bank state is read back on q_fb.
module jk_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10,
    parameter int CW    = 8
) (
    input logic            clk,
    input logic            rst,
    jk_count_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD-1);

    state_t           state;
    state_t           state_n;
    logic             dir_r;
    logic [CW-1:0]    steps_left;
    logic             load;
    logic             dec;
    logic             zap;
    logic             done_c;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;

    // Out-of-range feedback snaps to 0 going up and to MOD-1 going down.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] x,
        input logic             up
    );
        logic [WIDTH:0] xw;
        xw = {1'b0, x};
        if (up)
            next_val = (xw + 1'b1 >= MOD_W) ? '0 : x + 1'b1;
        else
            next_val = (x == '0 || xw >= MOD_W) ? TOP : x - 1'b1;
    endfunction

    assign t = next_val(bus.q_fb, dir_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dir_r      <= 1'b0;
            steps_left <= '0;
        end else begin
            state <= state_n;
            if (zap)
                steps_left <= '0;
            else if (load) begin
                steps_left <= bus.steps;
                dir_r      <= bus.dir;
            end else if (dec)
                steps_left <= steps_left - 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        dec     = 1'b0;
        zap     = 1'b0;
        done_c  = 1'b0;
        j_c     = '0;
        k_c     = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = bus.clear_first ? CLEAR : RUN;
                end
            end
            CLEAR: begin
                k_c     = '1;
                state_n = RUN;
            end
            RUN: begin
                if (steps_left == '0) begin
                    state_n = DONE;
                end else if (bus.en) begin
                    j_c = ~bus.q_fb & t;
                    k_c = bus.q_fb & ~t;
                    dec = 1'b1;
                    if (steps_left == CW'(1))
                        state_n = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Abort wins over stepping and completion, and swallows done.
        if (bus.abort && state != IDLE) begin
            j_c     = '0;
            k_c     = '0;
            dec     = 1'b0;
            done_c  = 1'b0;
            zap     = 1'b1;
            state_n = IDLE;
        end
    end

    assign bus.j          = j_c;
    assign bus.k          = k_c;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_c;
    assign bus.steps_left = steps_left;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl driving a behavioural jk_ff bank.
// Table of commands plus hand sequences for pause, abort and reset.
module tb_jk_count_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic ld;
    logic [3:0] ld_val;
    logic [3:0] q;

    always #5 clk = ~clk;

    jk_count_ctrl_if #(.WIDTH(4), .CW(8)) bus ();

    jk_count_ctrl #(.WIDTH(4), .MOD(10), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // jk_ff bank; ld lets the bench preset arbitrary (even illegal) states
    always @(posedge clk) begin
        if (rst)
            q <= 4'd0;
        else if (ld)
            q <= ld_val;
        else
            q <= (bus.j & ~q) | (~bus.k & q);
    end

    assign bus.q_fb = q;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic       dir;
        logic       clr;
        logic [7:0] steps;
        logic [3:0] q0;
        logic [3:0] exp_q;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [3:0] v);
        ld     = 1'b1;
        ld_val = v;
        step();
        ld     = 1'b0;
    endtask

    task automatic issue(input logic d, input logic c, input logic [7:0] n);
        bus.start       = 1'b1;
        bus.dir         = d;
        bus.clear_first = c;
        bus.steps       = n;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cyc);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) break;
            cyc++;
            step();
        end
        if (bus.busy) begin
            chk({name, "_timeout"}, 1, 0);
            cyc = -1;
        end
    endtask

    // Scoreboard: every done pulse must match a queued final bank value.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0)
                chk("unexpected_done", 1, 0);
            else
                chk("done_q", int'(q), int'(sb.pop_front()));
        end
    end

    initial begin
        int cyc;
        vecs[0] = '{1'b1, 1'b0, 8'd3,  4'd0,  4'd3, 4};
        vecs[1] = '{1'b1, 1'b0, 8'd4,  4'd8,  4'd2, 5};
        vecs[2] = '{1'b0, 1'b0, 8'd1,  4'd0,  4'd9, 2};
        vecs[3] = '{1'b1, 1'b1, 8'd2,  4'd7,  4'd2, 4};
        vecs[4] = '{1'b0, 1'b0, 8'd0,  4'd5,  4'd5, 2};
        vecs[5] = '{1'b0, 1'b1, 8'd0,  4'd3,  4'd0, 3};
        vecs[6] = '{1'b1, 1'b0, 8'd1,  4'd12, 4'd0, 2};
        vecs[7] = '{1'b0, 1'b0, 8'd1,  4'd14, 4'd9, 2};
        vecs[8] = '{1'b0, 1'b0, 8'd13, 4'd2,  4'd9, 14};
        vecs[9] = '{1'b1, 1'b0, 8'd25, 4'd9,  4'd4, 26};

        rst             = 1'b1;
        ld              = 1'b0;
        ld_val          = 4'd0;
        bus.start       = 1'b0;
        bus.dir         = 1'b0;
        bus.clear_first = 1'b0;
        bus.steps       = 8'd0;
        bus.en          = 1'b0;
        bus.abort       = 1'b0;

        step();
        step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sl", int'(bus.steps_left), 0);
        chk("rst_j", int'(bus.j), 0);
        chk("rst_k", int'(bus.k), 0);
        chk("rst_q", int'(q), 0);
        rst    = 1'b0;
        bus.en = 1'b1;
        step();

        // Step-by-step count 0 -> 3
        sb.push_back(4'd3);
        issue(1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_q%0d", i), int'(q), i);
            chk($sformatf("seq_sl%0d", i), int'(bus.steps_left), 3 - i);
            chk($sformatf("seq_done%0d", i), int'(bus.done), (i == 3) ? 1 : 0);
            step();
        end
        chk("seq_idle", int'(bus.busy), 0);

        for (int v = 0; v < 10; v++) begin
            preset(vecs[v].q0);
            sb.push_back(vecs[v].exp_q);
            issue(vecs[v].dir, vecs[v].clr, vecs[v].steps);
            wait_idle($sformatf("vec%0d", v), cyc);
            chk($sformatf("vec%0d_cyc", v), cyc, vecs[v].exp_cyc);
            chk($sformatf("vec%0d_q", v), int'(q), int'(vecs[v].exp_q));
            chk($sformatf("vec%0d_sl", v), int'(bus.steps_left), 0);
        end

        // Pause: en low after the second step
        preset(4'd0);
        sb.push_back(4'd5);
        issue(1'b1, 1'b0, 8'd5);
        step();
        step();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("pause_q%0d", i), int'(q), 2);
            chk($sformatf("pause_sl%0d", i), int'(bus.steps_left), 3);
        end
        bus.en = 1'b1;
        wait_idle("pause", cyc);
        chk("pause_final", int'(q), 5);

        // Abort mid-run with four steps left
        preset(4'd0);
        issue(1'b1, 1'b0, 8'd8);
        repeat (4) step();
        chk("abort_pre_sl", int'(bus.steps_left), 4);
        bus.abort = 1'b1;
        #1;
        chk("abort_j", int'(bus.j), 0);
        chk("abort_k", int'(bus.k), 0);
        step();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_sl", int'(bus.steps_left), 0);
        repeat (3) step();
        chk("abort_q", int'(q), 4);

        // Abort while idle does nothing
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("idle_abort_busy", int'(bus.busy), 0);

        // start held through the command, including the DONE cycle
        preset(4'd0);
        sb.push_back(4'd2);
        bus.start = 1'b1;
        bus.dir   = 1'b1;
        bus.clear_first = 1'b0;
        bus.steps = 8'd2;
        step();
        bus.steps = 8'd9;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) break;
            step();
        end
        chk("hold_done_seen", int'(bus.done), 1);
        step();
        bus.start = 1'b0;
        chk("hold_idle", int'(bus.busy), 0);
        chk("hold_q", int'(q), 2);

        // Reset in the middle of a command
        preset(4'd1);
        issue(1'b1, 1'b0, 8'd5);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_sl", int'(bus.steps_left), 0);
        chk("mrst_q", int'(q), 0);
        rst = 1'b0;
        repeat (2) step();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
